projectile_scheduler: RTL

- Sequences projectile spawns for the spaceship.
- Takes a debounced single-cycle fire pulse, the current 4-bit ship angle and the 2-bit shooting mode, and expands each accepted trigger into a volley of spawn commands.
- Each spawn command is handed to the projectile datapath over a valid/ready handshake.
- Enforces burst spacing and a post-volley cooldown, both measured in frame ticks. Sits between the spaceship controller and the projectile engine.

---
 rtl/projectile_scheduler_pkg.sv | 29 ++
 rtl/projectile_scheduler_tick_counter.sv | 30 +++
 rtl/projectile_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/projectile_scheduler_pkg.sv
// Shared encodings for the projectile scheduler: shooting modes, spawn types,
// FSM states and the spread-angle helper.
package projectile_scheduler_pkg;
  localparam int ANGLE_W = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SPREAD = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_SAFE   = 2'd3
  } mode_e;

  localparam logic TYPE_NORMAL = 1'b0;
  localparam logic TYPE_SPREAD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_COOLDOWN
  } state_e;

  // Spread shot idx (0,1,2) fans out to base-1, base, base+1 with 4-bit wrap.
  function automatic logic [ANGLE_W-1:0] spread_angle(input logic [ANGLE_W-1:0] base,
                                                      input logic [2:0]         idx);
    return base + ANGLE_W'(idx) - ANGLE_W'(1);
  endfunction
endpackage

// File: rtl/projectile_scheduler_tick_counter.sv
// Loadable down-counter of frame ticks; expire is high once the loaded number
// of ticks has elapsed (on the edge that consumes the last tick, or at once for 0).
module tick_counter
  import projectile_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign expire = (cnt_q == '0) || (tick && (cnt_q == CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/projectile_scheduler.sv
// Expands accepted fire requests into volleys of spawn commands (single, spread,
// burst) over a valid/ready handshake, with tick-based burst spacing and cooldown.
module projectile_scheduler
  import projectile_scheduler_pkg::*;
#(
  parameter int BURST_LEN      = 3,
  parameter int BURST_GAP      = 4,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               fire,
  input  logic [1:0]         mode,
  input  logic [ANGLE_W-1:0] angle,
  output logic               spawn_valid,
  input  logic               spawn_ready,
  output logic [ANGLE_W-1:0] spawn_angle,
  output logic               spawn_type,
  output logic               busy,
  output logic               fire_dropped,
  output logic [7:0]         shots_fired
);
  localparam logic [2:0]       LAST_BURST = 3'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(BURST_GAP);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_TICKS);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [2:0]         shot_q, shot_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic [ANGLE_W-1:0] spawn_angle_q, spawn_angle_d;
  logic               spawn_type_q, spawn_type_d;
  logic               busy_q, busy_d;
  logic               fire_dropped_q, fire_dropped_d;
  logic [7:0]         shots_q, shots_d;
  logic               handshake, cnt_load, cnt_expire;
  logic [CNT_W-1:0]   cnt_load_val;

  assign handshake = spawn_valid_q && spawn_ready;

  tick_counter u_tick_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (tick),
    .expire   (cnt_expire)
  );

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    angle_d        = angle_q;
    shot_d         = shot_q;
    shots_d        = shots_q;
    fire_dropped_d = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;

    if (handshake) shots_d = shots_q + 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          if (mode_e'(mode) == MODE_SAFE) begin
            fire_dropped_d = 1'b1;
          end else begin
            mode_d  = mode_e'(mode);
            angle_d = angle;
            shot_d  = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        fire_dropped_d = fire;
        if (handshake) begin
          // Loading the counter here keeps a tick on the handshake edge from counting.
          state_d      = ST_COOLDOWN;
          cnt_load     = 1'b1;
          cnt_load_val = COOL_LOAD;
          if (mode_q == MODE_SPREAD && shot_q != 3'd2) begin
            state_d  = ST_ISSUE;
            cnt_load = 1'b0;
            shot_d   = shot_q + 3'd1;
          end else if (mode_q == MODE_BURST && shot_q < LAST_BURST) begin
            state_d      = ST_GAP;
            cnt_load_val = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        fire_dropped_d = fire;
        if (cnt_expire) begin
          shot_d  = shot_q + 3'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_COOLDOWN: begin
        fire_dropped_d = fire;
        if (cnt_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    spawn_valid_d = (state_d == ST_ISSUE);
    busy_d        = (state_d != ST_IDLE);
    spawn_angle_d = spawn_angle_q;
    spawn_type_d  = spawn_type_q;
    if (spawn_valid_d) begin
      spawn_angle_d = (mode_d == MODE_SPREAD) ? spread_angle(angle_d, shot_d) : angle_d;
      spawn_type_d  = (mode_d == MODE_SPREAD) ? TYPE_SPREAD : TYPE_NORMAL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_SINGLE;
      angle_q        <= '0;
      shot_q         <= '0;
      spawn_valid_q  <= 1'b0;
      spawn_angle_q  <= '0;
      spawn_type_q   <= TYPE_NORMAL;
      busy_q         <= 1'b0;
      fire_dropped_q <= 1'b0;
      shots_q        <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      angle_q        <= angle_d;
      shot_q         <= shot_d;
      spawn_valid_q  <= spawn_valid_d;
      spawn_angle_q  <= spawn_angle_d;
      spawn_type_q   <= spawn_type_d;
      busy_q         <= busy_d;
      fire_dropped_q <= fire_dropped_d;
      shots_q        <= shots_d;
    end
  end

  assign spawn_valid  = spawn_valid_q;
  assign spawn_angle  = spawn_angle_q;
  assign spawn_type   = spawn_type_q;
  assign busy         = busy_q;
  assign fire_dropped = fire_dropped_q;
  assign shots_fired  = shots_q;
endmodule
